// File: rtl/i2c_tx_feeder.sv
// Purpose: queues board write bytes and hands them one at a time to the I2C master.
// Latency: master_en rises one clk edge after a push lands in an empty FIFO (if the master is idle).
// Backpressure: waits for the master's ready to fall and then return before issuing the next byte; pushes into a full FIFO are dropped.
//
// Ports:
//   clk, rst      - system clock shared with the master; asynchronous active-high reset
//   wr_en/wr_data - one byte pushed per high cycle of wr_en
//   clr_err       - synchronous clear of the overflow and timeout_err sticky flags
//   master_ready  - master idle indication (high = idle)
//   master_data   - byte presented to the master, held for the whole transaction
//   master_en     - enable request to the master
//   full/empty/level - FIFO status
//   busy          - a transaction is in flight (state is not IDLE)
//   overflow      - sticky: a push arrived while full
//   timeout_err   - sticky: the master never dropped ready after enable
//   sent_cnt      - completed transactions, wraps at 255
module i2c_tx_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_err,
  input  logic                   master_ready,
  output logic [DATA_W-1:0]      master_data,
  output logic                   master_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   overflow,
  output logic                   timeout_err,
  output logic [7:0]             sent_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  to_cnt;

  logic push, pop, to_hit, sent_inc;

  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);
  assign busy  = (state != ST_IDLE);

  // A push into a full FIFO is dropped even when a pop frees a slot in the
  // same cycle, because full is judged on the pre-edge occupancy.
  assign push = wr_en && !full;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ------------------------------------------------------- state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    to_hit    = 1'b0;
    sent_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && master_ready) begin
          pop       = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!master_ready) begin
          state_nxt = ST_BUSY;
        end else if (to_cnt == CNT_LAST) begin
          // Master never acknowledged: abandon this byte.
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (master_ready) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        sent_inc  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------- registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master_data <= '0;
      master_en   <= 1'b0;
      to_cnt      <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      sent_cnt    <= '0;
    end else begin
      if (pop) begin
        master_data <= mem[rd_ptr];
        to_cnt      <= '0;
      end else if (state == ST_REQ) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // Enable is high exactly while the FSM sits in REQ.
      master_en <= (state_nxt == ST_REQ);

      if (sent_inc) begin
        sent_cnt <= sent_cnt + 1'b1;
      end

      // Setting events take priority over clr_err.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_tx_feeder.sv
// Bench for i2c_tx_feeder: directed scenarios followed by a randomized run.
// The stimulus side predicts FIFO acceptance and queues expected bytes; a
// monitor tracks a transaction-level model of the handshake and checks the DUT.
module tb_i2c_tx_feeder;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_err = 1'b0;
  logic       master_ready;
  logic [7:0] master_data;
  logic       master_en, full, empty, busy, overflow, timeout_err;
  logic [3:0] level;
  logic [7:0] sent_cnt;

  // master_ready comes either from the random responder or from directed code
  logic rand_mode  = 1'b0;
  logic dir_ready  = 1'b1;
  logic resp_ready = 1'b1;
  assign master_ready = rand_mode ? resp_ready : dir_ready;

  // Shared model state
  logic [7:0] exp_q[$];
  int         m_lvl = 0;
  bit         m_busy = 1'b0;
  logic [7:0] m_sent = 8'h00;
  bit         pend_acc = 1'b0;
  bit         pend_ovf = 1'b0;

  int checks = 0;
  int failures = 0;

  i2c_tx_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr_err     (clr_err),
    .master_ready(master_ready),
    .master_data (master_data),
    .master_en   (master_en),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .sent_cnt    (sent_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and predict acceptance.
  task automatic cyc(input bit w, input logic [7:0] d, input bit c);
    @(negedge clk);
    wr_en    = w;
    wr_data  = d;
    clr_err  = c;
    pend_acc = w && (m_lvl < DEPTH);
    pend_ovf = w && (m_lvl == DEPTH);
    if (pend_acc) exp_q.push_back(d);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((m_lvl != 0 || m_busy) && n < bound) begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_bound", 32'(n < bound), 32'd1);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},   32'(master_en),   32'd0);
    chk({tag, "_data"}, 32'(master_data), 32'd0);
    chk({tag, "_full"}, 32'(full),        32'd0);
    chk({tag, "_empty"},32'(empty),       32'd1);
    chk({tag, "_level"},32'(level),       32'd0);
    chk({tag, "_busy"}, 32'(busy),        32'd0);
    chk({tag, "_ovf"},  32'(overflow),    32'd0);
    chk({tag, "_to"},   32'(timeout_err), 32'd0);
    chk({tag, "_sent"}, 32'(sent_cnt),    32'd0);
  endtask

  // ------------------------------------------------------------ responder
  initial begin
    int rs, dly;
    rs = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!rand_mode) begin
        rs = 0;
        resp_ready = 1'b1;
      end else begin
        case (rs)
          0: begin
            resp_ready = 1'b1;
            if (master_en) begin
              if ($urandom_range(0, 5) == 0) rs = 3;
              else begin
                dly = $urandom_range(0, 3);
                rs = 1;
              end
            end
          end
          1: if (dly == 0) begin
               resp_ready = 1'b0;
               dly = $urandom_range(0, 5);
               rs = 2;
             end else dly--;
          2: if (dly == 0) begin
               resp_ready = 1'b1;
               rs = 0;
             end else dly--;
          default: if (!master_en) rs = 0;
        endcase
      end
    end
  end

  // -------------------------------------------------------------- monitor
  initial begin
    bit en_e, bph, dw, rise_e, to_set, ovf_e, to_e, c, r, pa, po;
    int hi;
    logic [7:0] cur;
    en_e = 0; bph = 0; dw = 0; ovf_e = 0; to_e = 0; hi = 0; cur = 8'h00;
    forever begin
      @(posedge clk);
      c  = clr_err;
      r  = master_ready;
      pa = pend_acc;
      po = pend_ovf;
      #1;
      if (rst) begin
        en_e = 0; bph = 0; dw = 0; ovf_e = 0; to_e = 0; hi = 0; cur = 8'h00;
        m_lvl = 0; m_sent = 8'h00; m_busy = 1'b0;
        exp_q.delete();
      end else begin
        rise_e = 0;
        to_set = 0;
        if (en_e) begin
          if (!r) begin
            en_e = 0;
            bph = 1;
          end else if (hi == TIMEOUT) begin
            en_e = 0;
            to_set = 1;
          end else hi++;
        end else if (bph) begin
          if (r) begin
            bph = 0;
            dw = 1;
          end
        end else if (dw) begin
          dw = 0;
          m_sent++;
        end else if (m_lvl > 0 && r) begin
          rise_e = 1;
          en_e = 1;
          hi = 1;
        end
        m_lvl  = m_lvl + int'(pa) - int'(rise_e);
        ovf_e  = po || (ovf_e && !c);
        to_e   = to_set || (to_e && !c);
        m_busy = en_e || bph || dw;

        chk("en", 32'(master_en), 32'(en_e));
        if (rise_e) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_queue actual=empty expected=byte at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
            chk("data", 32'(master_data), 32'(cur));
          end
        end else if (m_busy) begin
          chk("data_hold", 32'(master_data), 32'(cur));
        end
        chk("level", 32'(level), 32'(m_lvl));
        chk("full", 32'(full), 32'(m_lvl == DEPTH));
        chk("empty", 32'(empty), 32'(m_lvl == 0));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overflow", 32'(overflow), 32'(ovf_e));
        chk("timeout_err", 32'(timeout_err), 32'(to_e));
        chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] s0;
    bit stall;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);

    // Single byte, master acknowledges after 50 busy cycles
    cyc(1'b1, 8'h1D, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_en_early", 32'(master_en), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_en", 32'(master_en), 32'd1);
    chk("t1_data", 32'(master_data), 32'h1D);
    dir_ready = 1'b0;
    repeat (50) cyc(1'b0, 8'h00, 1'b0);
    chk("t1_en_low", 32'(master_en), 32'd0);
    dir_ready = 1'b1;
    repeat (4) cyc(1'b0, 8'h00, 1'b0);
    chk("t1_sent", 32'(sent_cnt), 32'd1);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // Fill past capacity with the master held busy
    dir_ready = 1'b0;
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'($urandom), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_level", 32'(level), 32'd8);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    chk("t3_level_kept", 32'(level), 32'd8);

    // Pop and push in the same cycle while full
    cyc(1'b1, 8'hEE, 1'b0);
    dir_ready = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    dir_ready = 1'b0;
    chk("t6_level", 32'(level), 32'(DEPTH - 1));
    chk("t6_ovf", 32'(overflow), 32'd1);
    chk("t6_en", 32'(master_en), 32'd1);
    rand_mode = 1'b1;
    drain(3000);

    // Master never acknowledges: both bytes time out
    rand_mode = 1'b0;
    dir_ready = 1'b1;
    s0 = m_sent;
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b1, 8'h6B, 1'b0);
    repeat (2 * (TIMEOUT + 2) + 6) cyc(1'b0, 8'h00, 1'b0);
    chk("t4_to", 32'(timeout_err), 32'd1);
    chk("t4_sent", 32'(sent_cnt), 32'(s0));
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);

    // Asynchronous reset while BUSY with three bytes queued
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    dir_ready = 1'b0;
    cyc(1'b1, 8'h44, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_level", 32'(level), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("t5_arst");
    @(negedge clk);
    rst = 1'b0;
    dir_ready = 1'b1;

    // Randomized traffic with periodic stalls to provoke overflow
    rand_mode = 1'b1;
    for (int k = 0; k < 500; k++) begin
      stall = (k % 125) >= 100;
      rand_mode = !stall;
      if (stall) dir_ready = 1'b0;
      cyc(stall ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0),
          8'($urandom), $urandom_range(0, 24) == 0);
    end
    rand_mode = 1'b1;
    drain(3000);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    chk("final_sent", 32'(sent_cnt), 32'(m_sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_tx_feeder.md
Name: i2c_tx_feeder

Overview:
Upstream stage for the I2C master controller. Queues write bytes from the board (switch bank plus strobe) in a small FIFO. Presents one byte at a time on the master's data_in with a single enable request, then waits for the master's ready to complete a busy/idle cycle before issuing the next byte. Provides status for LEDs and debug, including a sticky overflow flag and a handshake timeout flag.

Parameters:
DATA_W, 8, byte width; must match the master's data_in width.
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT, 1024, clk cycles allowed for the master to drop ready after enable is raised.

Ports:
clk  input  1  system clock; same clock as the master.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  push strobe, one byte per high cycle.
wr_data  input  DATA_W  byte to push.
clr_err  input  1  synchronous clear of the overflow and timeout flags.
master_ready  input  1  ready output of the master; high means idle.
master_data  output  DATA_W  data to the master's data_in; held stable during a transaction.
master_en  output  1  enable to the master.
full  output  1  FIFO full.
empty  output  1  FIFO empty.
level  output  log2(DEPTH)+1  current FIFO occupancy.
busy  output  1  high whenever state is not IDLE.
overflow  output  1  sticky flag: a push arrived while the FIFO was full.
timeout_err  output  1  sticky flag: the master did not acknowledge enable within TIMEOUT cycles.
sent_cnt  output  8  count of completed transactions; wraps 255 to 0.

Behaviour:
- Reset (async, active-high):
  - state IDLE; FIFO pointers and level cleared.
  - Outputs: master_data=0, master_en=0, full=0, empty=1, level=0, busy=0, overflow=0, timeout_err=0, sent_cnt=0.
  - Reset mid-transaction drops master_en immediately and discards all queued data.
- FIFO:
  - Push accepted when wr_en=1 and full=0.
  - When wr_en=1 and full=1, the byte is dropped and overflow is set. This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
  - full = (level==DEPTH); empty = (level==0).
- State machine: IDLE, REQ, BUSY, DONE.
  - IDLE: when empty=0 and master_ready=1, pop the head byte into master_data, set master_en=1, clear the timeout counter, and go to REQ. If master_ready=0, remain in IDLE.
  - REQ: master_en held at 1.
    - If master_ready=0: master_en goes to 0 and the state moves to BUSY.
    - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with ready still high: master_en goes to 0, timeout_err is set, the byte is discarded (sent_cnt unchanged), and the state returns to IDLE.
  - BUSY: master_en=0 and master_data held. When master_ready returns to 1, go to DONE.
  - DONE: for one cycle, increment sent_cnt, then go to IDLE.
- Latency: master_en rises on the 1st clk edge after a push into an empty FIFO, provided the master is idle. The minimum gap between consecutive enables is 3 cycles after ready returns high (DONE to IDLE to REQ).
- master_data changes only on the IDLE-to-REQ transition.
- clr_err clears both sticky flags. If clr_err and a setting event occur in the same cycle, set wins.
- busy = (state != IDLE). All outputs are registered except full, empty and busy, which are decoded from registers.

Test Plan:
- Push 0x1D into an empty FIFO with master_ready=1 -> master_en=1 next cycle with master_data=0x1D. Model ready low for 50 cycles then high -> master_en drops when ready falls, sent_cnt=1, empty=1, busy=0.
- Push 0xA1, 0xB2, 0xC3 back-to-back using the real i2c_master_controller and slave -> the slave receives 0xA1, 0xB2, 0xC3 in order, sent_cnt=3, and master_data never changes while ready=0.
- Hold master_ready=0, then push 9 bytes with DEPTH=8 -> level=8, full=1, overflow=1, and the 9th byte is lost. Pulse clr_err -> overflow=0.
- Hold master_ready=1 permanently after enable (model never acknowledges) with TIMEOUT=16 -> master_en is high for exactly 16 cycles, then timeout_err=1, the byte is discarded, sent_cnt=0, and the next byte is issued.
- Assert rst while in BUSY with 3 bytes queued -> master_en=0 and level=0 immediately (asynchronously), with all flags clear.
- With level=DEPTH, pop in IDLE while wr_en=1 in the same cycle -> the push is dropped, overflow=1, and level=DEPTH-1.
